bcd_score_counter: RTL and testbench
====================================

Name: bcd_score_counter

Overview:
- Multi-digit BCD up counter that accumulates game points; the counting-up counterpart of the bomb countdown digits.
- Accepts an "add N points" request and applies it one unit per clock, rippling carries across BCD digits.
- Drives the score display: one 4-bit BCD nibble per digit into the seven-segment decoders.
- Sits between the game-event logic (enemy killed, power-up taken) and the display path.

Parameters:
- DIGITS, 3, number of BCD digits; count range 0 to 10^DIGITS-1.
- SATURATE, 1, 1 = hold at all-9s on overflow; 0 = wrap to all-0s.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear, highest priority after reset.
- add_valid  input  1  request to add add_amount; sampled only when busy=0.
- add_amount  input  4  points to add, 0..15 (binary).
- busy  output  1  high while a request is being applied.
- count  output  4*DIGITS  packed BCD; digit 0 in bits [3:0].
- tc  output  1  combinational; high when every digit equals 9.
- overflow  output  1  sticky; set on a saturate or wrap event.

Behaviour:
- Reset (async, active-high): all digits 0, overflow=0, busy=0, state IDLE, remaining=0.
- clear=1 at a clock edge: same values as reset, applied synchronously; overrides any add in that cycle.
- State IDLE:
  - add_valid=1 and add_amount!=0: latch remaining=add_amount, go to ADDING; busy=1 from the next cycle.
  - add_amount=0: no-op; stay in IDLE.
- State ADDING, each cycle:
  - count increments by 1 (BCD, digit 9 -> 0 with carry into the next digit); remaining decrements.
  - When remaining reaches 0 after this cycle's increment, return to IDLE.
  - An amount of N therefore takes exactly N busy cycles; the final count is visible the cycle busy falls.
- add_valid while busy=1: ignored, not queued. The requester must hold or retry.
- Overflow at all-9s with an increment due:
  - SATURATE=1: count holds at all-9s, overflow=1, remaining forced to 0, return to IDLE on the next edge.
  - SATURATE=0: count wraps to all-0s, overflow=1, adding continues.
- overflow clears only on reset or clear.
- tc depends only on count, with no added latency.
- Digits never hold a value above 9.

Optional Feature:
- Macro SCORE_DOUBLE_EN.
- Defined:
  - Adds input port double_pts (1 bit).
  - If double_pts=1 when a request is accepted, remaining = 2*add_amount (5-bit register, max 30 busy cycles).
- Undefined:
  - No double_pts port; remaining is 4 bits and equals add_amount.
- All other behaviour is identical in both builds.

Decomposition:
- Package score_pkg:
  - typedef bcd_digit_t (logic [3:0]).
  - constant BCD_MAX = 4'd9.
  - enum score_state_t {IDLE, ADDING}.
- Sub-module bcd_up_digit, instantiated DIGITS times in a generate loop:
  - Ports: clk, reset, clear, inc (carry-in), digit, carry_out.
  - carry_out is combinational: inc && digit==9.
- Top level owns: the FSM, the remaining counter, saturate/wrap handling, overflow and tc.

Test Plan:
- Reset asserted mid-ADDING (after 2 of 7 increments): count=000, busy=0 immediately, without waiting for a clock edge; after release, new requests are accepted.
- From 000, add_amount=7: busy high exactly 7 cycles; count=007; tc=0, overflow=0.
- From 095, add_amount=9: ripple through 099 -> 100; final count=104; no digit ever exceeds 9.
- From 995 with SATURATE=1, add_amount=10: count sticks at 999, tc=1, overflow=1, busy falls after 5 cycles.
- Same start with SATURATE=0: count ends at 005, overflow=1, busy high 10 cycles.
- While busy: add_valid=1 with add_amount=3 is ignored. A clear pulse mid-ADDING gives count=000, busy=0, overflow=0. With SCORE_DOUBLE_EN, double_pts=1 and add_amount=4 gives 8 increments.

Source files
------------

// File: rtl/bcd_score_counter_pkg.sv
// Shared types and constants for the BCD score counter and its digit cells.
package score_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic {
    IDLE,
    ADDING
  } score_state_t;

endpackage

// File: rtl/bcd_score_counter_digit.sv
// One BCD digit cell: counts 0..9 on inc, and passes a carry on when it rolls over from 9.
module bcd_up_digit
  import score_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output bcd_digit_t digit,
  output logic       carry_out
);

  bcd_digit_t digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (inc) begin
      digit_d = (digit_q >= BCD_MAX) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else if (clear) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit     = digit_q;
  assign carry_out = inc && (digit_q == BCD_MAX);

endmodule

// File: rtl/bcd_score_counter.sv
// Multi-digit BCD score accumulator: applies an "add N" request one unit per clock.
// Optional build macro SCORE_DOUBLE_EN adds a double_pts input that doubles the accepted amount.
module bcd_score_counter
  import score_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int SATURATE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                add_valid,
  input  logic [3:0]          add_amount,
`ifdef SCORE_DOUBLE_EN
  input  logic                double_pts,
`endif
  output logic                busy,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                overflow
);

`ifdef SCORE_DOUBLE_EN
  localparam int REM_W = 5;
`else
  localparam int REM_W = 4;
`endif

  score_state_t     state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;

  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] is_nine;
  bcd_digit_t        digit_w [DIGITS];
  logic              adding;
  logic              sat_hold;

  assign adding   = (state_q == ADDING);
  assign tc       = &is_nine;
  // At all-9s a saturating counter must not feed the ripple chain at all.
  assign sat_hold = adding && tc && (SATURATE != 0);
  assign carry[0] = adding && !sat_hold;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_up_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .inc       (carry[i]),
      .digit     (digit_w[i]),
      .carry_out (carry[i+1])
    );
    assign count[4*i +: 4] = digit_w[i];
    assign is_nine[i]      = (digit_w[i] == BCD_MAX);
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q || sat_hold || carry[DIGITS];
    unique case (state_q)
      IDLE: begin
        if (add_valid && (add_amount != 4'd0)) begin
          state_d = ADDING;
`ifdef SCORE_DOUBLE_EN
          rem_d   = double_pts ? {add_amount, 1'b0} : {1'b0, add_amount};
`else
          rem_d   = add_amount;
`endif
        end
      end
      ADDING: begin
        if (sat_hold) begin
          rem_d   = '0;
          state_d = IDLE;
        end else begin
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = adding;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Scoreboard bench for bcd_score_counter: a saturating and a wrapping instance share stimulus.
module tb_bcd_score_counter;

  logic        clk = 1'b0;
  logic        reset, clear, add_valid;
  logic [3:0]  add_amount;
`ifdef SCORE_DOUBLE_EN
  logic        double_pts;
`endif
  logic        busy_s, tc_s, ovf_s;
  logic        busy_w, tc_w, ovf_w;
  logic [11:0] count_s, count_w;

  always #5 clk = ~clk;

  bcd_score_counter #(.DIGITS(3), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .add_valid(add_valid), .add_amount(add_amount),
`ifdef SCORE_DOUBLE_EN
    .double_pts(double_pts),
`endif
    .busy(busy_s), .count(count_s), .tc(tc_s), .overflow(ovf_s)
  );

  bcd_score_counter #(.DIGITS(3), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .clear(clear), .add_valid(add_valid), .add_amount(add_amount),
`ifdef SCORE_DOUBLE_EN
    .double_pts(double_pts),
`endif
    .busy(busy_w), .count(count_w), .tc(tc_w), .overflow(ovf_w)
  );

  typedef struct {
    logic [11:0] cnt;
    logic        ov;
    int          cyc;
    int          tag;
  } exp_t;

  exp_t q_s[$];
  exp_t q_w[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_s  = 0;
  int   cyc_w  = 0;

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s tag=%0d got=%0h want=%0h", nm, tag, act, req);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic push(input int tag, input logic [11:0] cs, input logic os, input int ys,
                      input logic [11:0] cw, input logic ow, input int yw);
    exp_t e;
    e.tag = tag; e.cnt = cs; e.ov = os; e.cyc = ys;
    q_s.push_back(e);
    e.cnt = cw; e.ov = ow; e.cyc = yw;
    q_w.push_back(e);
  endtask

  // Monitor: a request is complete when busy falls; compare against the head of each queue.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      chk("digit_range_sat", i, 32'(count_s[4*i +: 4] <= 4'd9), 1);
      chk("digit_range_wrap", i, 32'(count_w[4*i +: 4] <= 4'd9), 1);
    end
    if (busy_s) begin
      cyc_s++;
    end else if (cyc_s > 0) begin
      if (q_s.size() == 0) begin
        chk("sat_unexpected_done", -1, 1, 0);
      end else begin
        e = q_s.pop_front();
        chk("sat_count", e.tag, count_s, e.cnt);
        chk("sat_overflow", e.tag, ovf_s, e.ov);
        chk("sat_tc", e.tag, tc_s, e.cnt == 12'h999);
        chk("sat_busy_cycles", e.tag, cyc_s, e.cyc);
      end
      cyc_s = 0;
    end
    if (busy_w) begin
      cyc_w++;
    end else if (cyc_w > 0) begin
      if (q_w.size() == 0) begin
        chk("wrap_unexpected_done", -1, 1, 0);
      end else begin
        e = q_w.pop_front();
        chk("wrap_count", e.tag, count_w, e.cnt);
        chk("wrap_overflow", e.tag, ovf_w, e.ov);
        chk("wrap_tc", e.tag, tc_w, e.cnt == 12'h999);
        chk("wrap_busy_cycles", e.tag, cyc_w, e.cyc);
      end
      cyc_w = 0;
    end
  end

  task automatic add(input logic [3:0] a);
    @(negedge clk);
    add_valid  = 1'b1;
    add_amount = a;
    @(negedge clk);
    add_valid  = 1'b0;
    add_amount = 4'd0;
  endtask

  task automatic wait_idle(input int tag);
    int n = 0;
    while ((busy_s || busy_w) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", tag, 32'(busy_s || busy_w), 0);
    @(negedge clk);
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    clear      = 1'b0;
    add_valid  = 1'b0;
    add_amount = 4'd0;
`ifdef SCORE_DOUBLE_EN
    double_pts = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_count", 0, count_s, 0);
    chk("reset_busy", 0, busy_s, 0);
    chk("reset_overflow", 0, ovf_s, 0);
    chk("reset_tc", 0, tc_s, 0);
    chk("reset_count_wrap", 0, count_w, 0);
    reset = 1'b0;

    push(1, 12'h007, 0, 7, 12'h007, 0, 7);
    add(4'd7);
    wait_idle(1);

    // Second request raised while busy must be dropped, not queued.
    push(2, 12'h012, 0, 5, 12'h012, 0, 5);
    @(negedge clk);
    add_valid = 1'b1; add_amount = 4'd5;
    @(negedge clk);
    add_amount = 4'd3;
    repeat (2) @(negedge clk);
    add_valid = 1'b0; add_amount = 4'd0;
    wait_idle(2);

    add(4'd0);
    repeat (3) @(negedge clk);
    chk("zero_add_count", 3, count_s, 12'h012);
    chk("zero_add_busy", 3, busy_s, 0);

    push(4, 12'h000, 0, 3, 12'h000, 0, 3);
    add(4'd9);
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_idle(4);

    for (int k = 1; k <= 6; k++) begin
      push(100 + k, to_bcd(15 * k), 0, 15, to_bcd(15 * k), 0, 15);
      add(4'd15);
      wait_idle(100 + k);
    end
    push(5, 12'h095, 0, 5, 12'h095, 0, 5);
    add(4'd5);
    wait_idle(5);
    push(6, 12'h104, 0, 9, 12'h104, 0, 9);
    add(4'd9);
    wait_idle(6);

    clear_pulse();
    for (int k = 1; k <= 66; k++) begin
      push(200 + k, to_bcd(15 * k), 0, 15, to_bcd(15 * k), 0, 15);
      add(4'd15);
      wait_idle(200 + k);
    end
    push(7, 12'h995, 0, 5, 12'h995, 0, 5);
    add(4'd5);
    wait_idle(7);
    push(8, 12'h999, 1, 5, 12'h005, 1, 10);
    add(4'd10);
    wait_idle(8);

    push(9, 12'h999, 1, 1, 12'h008, 1, 3);
    add(4'd3);
    wait_idle(9);

    clear_pulse();
    chk("clear_overflow", 10, ovf_s, 0);
    push(11, 12'h000, 0, 2, 12'h000, 0, 2);
    add(4'd7);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_busy", 11, busy_s, 0);
    chk("async_reset_count", 11, count_s, 0);
    chk("async_reset_busy_wrap", 11, busy_w, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_idle(11);

    push(12, 12'h004, 0, 4, 12'h004, 0, 4);
    add(4'd4);
    wait_idle(12);

`ifdef SCORE_DOUBLE_EN
    push(13, 12'h012, 0, 8, 12'h012, 0, 8);
    @(negedge clk);
    add_valid = 1'b1; add_amount = 4'd4; double_pts = 1'b1;
    @(negedge clk);
    add_valid = 1'b0; add_amount = 4'd0; double_pts = 1'b0;
    wait_idle(13);
`endif

    repeat (2) @(negedge clk);
    chk("sat_queue_drained", 99, q_s.size(), 0);
    chk("wrap_queue_drained", 99, q_w.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
